// File: rtl/packet_pkg.sv
// Shared types and constants for the port packet generator.
package packet_pkg;

    localparam int NUM_PORTS = 4;
    localparam int LFSR_W    = 16;

    // Feedback taps for x^16+x^14+x^13+x^11+1 on a left-shifting register:
    // state bits 15, 13, 12 and 10.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } gen_state_t;

    // One Fibonacci step: shift left, XOR of the taps enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    // Isolate the least significant set bit of a port mask.
    function automatic logic [NUM_PORTS-1:0] lowest_bit(input logic [NUM_PORTS-1:0] m);
        return m & (~m + 1'b1);
    endfunction

endpackage

// File: rtl/port_pkt_gen_lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when enabled.
module lfsr16
    import packet_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [LFSR_W-1:0] state
);

    // An all-zero seed would lock the register up, so substitute 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;

    // Shift register; holds its value when not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_EFF;
        end else if (en) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/port_pkt_gen.sv
// Pseudo-random packet source for one ingress port of switch_4port.
//
// state | meaning
// IDLE  | waiting for start
// SEND  | valid_in high, one packet this cycle
// GAP   | idle cycles between packets
// DONE  | one-cycle done pulse, then IDLE
module port_pkt_gen
    import packet_pkg::*;
#(
    parameter int               PORT_ID = 0,
    parameter int               CNT_W   = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_W-1:0]     num_pkts,
    input  logic [3:0]           gap,
    input  logic [NUM_PORTS-1:0] target_mask,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sent_cnt,
    output logic                 valid_in,
    output logic [3:0]           source_in,
    output logic [NUM_PORTS-1:0] target_in,
    output logic [7:0]           data_in
);

    localparam logic [NUM_PORTS-1:0] OWN_BIT = 4'b0001 << PORT_ID;
    localparam logic [3:0]           SRC_ID  = 4'(PORT_ID);

    gen_state_t           state;
    gen_state_t           next_state;
    logic [CNT_W-1:0]     num_q;
    logic [3:0]           gap_q;
    logic [3:0]           gap_cnt;
    logic [NUM_PORTS-1:0] emask_q;
    logic [NUM_PORTS-1:0] emask_in;
    logic [NUM_PORTS-1:0] emask_use;
    logic [NUM_PORTS-1:0] pkt_target;
    logic [LFSR_W-1:0]    lfsr;
    logic                 lfsr_en;
    logic                 last_pkt;
    logic                 start_ok;
    logic                 accept;

    // Middle LFSR bits do not feed any output.
    logic [3:0] unused_lfsr_mid;
    assign unused_lfsr_mid = lfsr[7:4];

    assign emask_in = target_mask & ~OWN_BIT;
    // The first packet is built on the start edge, before emask_q is loaded.
    assign emask_use = (state == ST_IDLE) ? emask_in : emask_q;
    assign last_pkt  = (sent_cnt == num_q);
    assign start_ok  = (num_pkts != '0) && (emask_in != '0);
    assign accept    = (state == ST_IDLE) && start;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .state (lfsr)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, LFSR enable and candidate packet target.
    always_comb begin
        next_state = state;
        lfsr_en    = 1'b0;
        pkt_target = lfsr[3:0] & emask_use;
        if (pkt_target == '0) begin
            pkt_target = lowest_bit(emask_use);
        end
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = start_ok ? ST_SEND : ST_DONE;
                end
            end
            ST_SEND: begin
                if (abort || last_pkt) begin
                    next_state = ST_DONE;
                end else if (gap_q != '0) begin
                    next_state = ST_GAP;
                end else begin
                    next_state = ST_SEND;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    next_state = ST_DONE;
                end else if (gap_cnt <= 4'd1) begin
                    next_state = ST_SEND;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        // Packet fields are registered on the edge entering SEND, so the
        // LFSR steps on that same edge, after its value has been used.
        lfsr_en = (next_state == ST_SEND);
    end

    // Run parameters captured when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q   <= '0;
            gap_q   <= '0;
            emask_q <= '0;
        end else if (accept) begin
            num_q   <= num_pkts;
            gap_q   <= gap;
            emask_q <= emask_in;
        end
    end

    // Inter-packet gap down-counter, loaded on entry to GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (next_state == ST_GAP && state != ST_GAP) begin
            gap_cnt <= gap_q;
        end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt - 4'd1;
        end
    end

    // Packet counter: cleared on start, counts on the edge raising valid_in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt <= '0;
        end else if (accept) begin
            sent_cnt <= start_ok ? CNT_W'(1) : '0;
        end else if (next_state == ST_SEND && sent_cnt != '1) begin
            sent_cnt <= sent_cnt + CNT_W'(1);
        end
    end

    // Registered packet strobe, payload and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_in  <= 1'b0;
            target_in <= '0;
            data_in   <= '0;
            source_in <= SRC_ID;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_in  <= (next_state == ST_SEND);
            target_in <= (next_state == ST_SEND) ? pkt_target : '0;
            data_in   <= (next_state == ST_SEND) ? lfsr[15:8] : '0;
            source_in <= SRC_ID;
            busy      <= (next_state == ST_SEND) || (next_state == ST_GAP);
            done      <= (next_state == ST_DONE);
        end
    end

endmodule
